// File: rtl/modulo_down_counter.sv
// modulo_down_counter: loadable modulo-N down counter with one-shot/periodic modes and a borrow pulse
module modulo_down_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_borrow,
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_count, w_next_count;
    logic             r_borrow, w_next_borrow, r_busy;
    // next-state, next-count and borrow decode; load outranks enable, enable only counts in RUN
    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_borrow = 1'b0;
        if (i_load) begin
            w_next_count = (32'(i_load_value) >= MODULUS) ? MAX : i_load_value;
            w_next_state = RUN;
        end else if (r_state == RUN && i_enable) begin
            if (r_count != '0) begin
                w_next_count = r_count - 1'b1;
            end else begin
                w_next_borrow = 1'b1;
                w_next_count  = i_auto_reload ? MAX : '0;
                w_next_state  = i_auto_reload ? RUN : EXPIRED;
            end
        end
    end
    // state and outputs registered; busy is registered from next state so it tracks state==RUN exactly
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_borrow <= w_next_borrow;
            r_busy   <= (w_next_state == RUN);
        end
    end
    assign o_count  = r_count;
    assign o_borrow = r_borrow;
    assign o_busy   = r_busy;
endmodule

// File: tb/tb_modulo_down_counter.sv
// tb_modulo_down_counter: directed self-checking bench for modulo_down_counter
module tb_modulo_down_counter;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, ld = 1'b0, ar = 1'b0;
    logic [2:0] lv = '0;
    logic [2:0] cnt;
    logic       borrow, busy;
    int         checks = 0, failures = 0;

    modulo_down_counter #(.WIDTH(3), .MODULUS(6)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_load(ld),
        .i_load_value(lv), .i_auto_reload(ar),
        .o_count(cnt), .o_borrow(borrow), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({cnt, busy, borrow} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: count=%0d busy=%0b borrow=%0b expected 0/0/0", cnt, busy, borrow);
        end
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({cnt, busy, borrow} !== {3'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL idle_enable[%0d]: count=%0d busy=%0b borrow=%0b expected 0/0/0", i, cnt, busy, borrow);
            end
        end
    endtask

    task automatic test_periodic();
        int exp_c[13] = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};
        ld = 1'b1; lv = 3'd5; ar = 1'b1; en = 1'b1;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy, borrow} !== {3'd5, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL periodic_load: count=%0d busy=%0b borrow=%0b expected 5/1/0", cnt, busy, borrow);
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if ({cnt, busy, borrow} !== {3'(exp_c[i]), 1'b1, (i == 5 || i == 11)}) begin
                failures++;
                $display("FAIL periodic[%0d]: count=%0d busy=%0b borrow=%0b expected %0d/1/%0b",
                         i, cnt, busy, borrow, exp_c[i], (i == 5 || i == 11));
            end
        end
    endtask

    task automatic test_oneshot();
        int exp_c[6] = '{1, 0, 0, 0, 0, 0};
        ld = 1'b1; lv = 3'd2; ar = 1'b0; en = 1'b1;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy, borrow} !== {3'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL oneshot_load: count=%0d busy=%0b borrow=%0b expected 2/1/0", cnt, busy, borrow);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({cnt, busy, borrow} !== {3'(exp_c[i]), (i < 2), (i == 2)}) begin
                failures++;
                $display("FAIL oneshot[%0d]: count=%0d busy=%0b borrow=%0b expected %0d/%0b/%0b",
                         i, cnt, busy, borrow, exp_c[i], (i < 2), (i == 2));
            end
        end
    endtask

    task automatic test_load_clamp();
        ld = 1'b1; lv = 3'd7; en = 1'b0;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy} !== {3'd5, 1'b1}) begin
            failures++;
            $display("FAIL load_clamp: count=%0d busy=%0b expected 5/1", cnt, busy);
        end
        en = 1'b1;
        tick();
        checks++;
        if (cnt !== 3'd4) begin
            failures++;
            $display("FAIL clamp_dec: count=%0d expected 4", cnt);
        end
        ld = 1'b1; lv = 3'd3;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy, borrow} !== {3'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL load_priority: count=%0d busy=%0b borrow=%0b expected 3/1/0", cnt, busy, borrow);
        end
    endtask

    task automatic test_enable_toggle();
        logic [2:0] en_v = 3'b101;
        int         exp_c[3] = '{2, 2, 1};
        for (int i = 0; i < 3; i++) begin
            en = en_v[2-i];
            tick();
            checks++;
            if ({cnt, busy, borrow} !== {3'(exp_c[i]), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL enable_toggle[%0d]: count=%0d busy=%0b borrow=%0b expected %0d/1/0",
                         i, cnt, busy, borrow, exp_c[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        ld = 1'b1; lv = 3'd3; ar = 1'b1; en = 1'b0;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy} !== {3'd3, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset: count=%0d busy=%0b expected 3/1", cnt, busy);
        end
        en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cnt, busy, borrow} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: count=%0d busy=%0b borrow=%0b expected 0/0/0", cnt, busy, borrow);
        end
        ld = 1'b1; lv = 3'd4;
        tick();
        checks++;
        if ({cnt, busy} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL load_in_reset: count=%0d busy=%0b expected 0/0", cnt, busy);
        end
        ld  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({cnt, busy, borrow} !== {3'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL post_reset_idle[%0d]: count=%0d busy=%0b borrow=%0b expected 0/0/0", i, cnt, busy, borrow);
            end
        end
        ld = 1'b1; lv = 3'd4;
        tick();
        ld = 1'b0;
        checks++;
        if ({cnt, busy} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL reload_after_reset: count=%0d busy=%0b expected 4/1", cnt, busy);
        end
        tick();
        checks++;
        if (cnt !== 3'd3) begin
            failures++;
            $display("FAIL count_after_reset: count=%0d expected 3", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_load_clamp();
        test_enable_toggle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/modulo_down_counter.md
MODULO_DOWN_COUNTER -- requirements
Module: modulo_down_counter

Interface
REQ-001 Parameter WIDTH, default 3, bit width of count and load_value.
REQ-002 Parameter MODULUS, default 6, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; SHALL act immediately, without waiting for a clock edge.
REQ-005 enable  input  1  decrement qualifier; sampled on the clock edge.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_value  input  WIDTH  start value for load.
REQ-008 auto_reload  input  1  1 = periodic mode; 0 = one-shot mode; sampled on the terminal decrement.
REQ-009 count  output  WIDTH  current count, registered.
REQ-010 borrow  output  1  registered one-cycle pulse on each underflow.
REQ-011 busy  output  1  high while state is RUN.

Function
REQ-012 FSM SHALL have 3 states: IDLE, RUN, EXPIRED; one encoding, registered.
REQ-013 load=1 in any state: count <= load_value, or MODULUS-1 if load_value >= MODULUS; state <= RUN; borrow <= 0.
REQ-014 load SHALL take priority over enable in the same cycle.
REQ-015 IDLE and EXPIRED: enable SHALL be ignored; count SHALL hold.
REQ-016 RUN, enable=0, load=0: count, state SHALL hold; borrow <= 0.
REQ-017 RUN, enable=1, count>0: count <= count-1; borrow <= 0.
REQ-018 RUN, enable=1, count==0, auto_reload=1: count <= MODULUS-1; borrow <= 1; state stays RUN.
REQ-019 RUN, enable=1, count==0, auto_reload=0: count stays 0; borrow <= 1; state <= EXPIRED.
REQ-020 borrow SHALL be high for exactly one clock per underflow; it is low in every other cycle.
REQ-021 In periodic mode with enable held high, borrow SHALL pulse every MODULUS clocks.
REQ-022 After a load of value V with enable held high, the first borrow SHALL appear V+1 clocks after the load edge.
REQ-023 count SHALL never hold a value >= MODULUS.
REQ-024 busy SHALL be a registered decode of state==RUN and SHALL carry no combinational path from the inputs.
REQ-025 Arithmetic SHALL be unsigned, WIDTH bits; the decrement from 0 SHALL never wrap to 2**WIDTH-1.

Reset
REQ-026 When reset is asserted: state=IDLE, count=0, borrow=0, busy=0; this SHALL apply in any state, including mid-count.
REQ-027 While reset is high, load and enable SHALL have no effect.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until the first load.

Verification
REQ-029 Reset, then enable=1 for 10 clocks with no load -> count=0, busy=0, borrow=0 throughout.
REQ-030 load 5, auto_reload=1, enable=1 held -> count 5,4,3,2,1,0,5,...; borrow high only on the edges where count goes 0->5, every 6 clocks.
REQ-031 load 2, auto_reload=0, enable=1 -> count 2,1,0,0; borrow=1 for one cycle, then state EXPIRED, busy=0; further enable -> no change.
REQ-032 load 7 (>= MODULUS) -> count=5, busy=1; simultaneous load 3 and enable=1 at count 4 -> count=3, no decrement.
REQ-033 enable toggled 1,0,1 from count 3 -> count 2,2,1; borrow stays 0.
REQ-034 Assert reset asynchronously between edges at count=3 in RUN -> count=0, busy=0, borrow=0 immediately; after release, enable ignored until load.
